// File: rtl/clk_div_mon_if.sv
// clk_div_mon_if: control inputs and measurement outputs of the divided-clock monitor.
// master = monitor side, slave = consumer/stimulus side.
interface clk_div_mon_if;
   logic        en;
   logic        div_in;
   logic        rise_tick;
   logic        fall_tick;
   logic [31:0] high_len;
   logic [31:0] period_len;
   logic        meas_valid;
   logic        period_err;
   logic        stuck;
   logic        locked;
   logic [15:0] period_cnt;

   modport master (
      input  en, div_in,
      output rise_tick, fall_tick, high_len, period_len, meas_valid,
             period_err, stuck, locked, period_cnt
   );

   modport slave (
      output en, div_in,
      input  rise_tick, fall_tick, high_len, period_len, meas_valid,
             period_err, stuck, locked, period_cnt
   );
endinterface

// File: rtl/clk_div_mon.sv
// clk_div_mon: measures div_in high time and period in clk cycles, flags out-of-tolerance periods and declares lock.
// All outputs registered one cycle after the edge is sampled; no backpressure; CLK_DIV_MON_STUCK_EN adds the edge timeout.
module clk_div_mon #(
   parameter logic [31:0] PERIOD_EXP = 32'd1000,
   parameter logic [31:0] HIGH_EXP   = 32'd500,
   parameter logic [31:0] TOL        = 32'd0,
   parameter logic [7:0]  LOCK_CNT   = 8'd4
) (
   input logic           clk,
   input logic           phase_rst,
   clk_div_mon_if.master mon
);

   typedef enum logic [1:0] {SEEK, HIGH, LOW} state_t;

   state_t      state_q, state_d;
   logic        div_prev, rise, fall;
   logic [31:0] run_cnt, hi_tmp;
   logic [7:0]  good_cnt, good_nx;
   logic        good_ok, meas_d, err_d, complete, cap_hi, clr_good;
`ifdef CLK_DIV_MON_STUCK_EN
   logic        tmo_hit, timeout;
   assign tmo_hit = ({1'b0, run_cnt} >= {PERIOD_EXP, 1'b0});
`endif

   assign rise = mon.div_in & ~div_prev;
   assign fall = ~mon.div_in & div_prev;

   // 33-bit signed difference so neither direction can wrap
   function automatic logic in_tol(input logic [31:0] meas, input logic [31:0] expv);
      logic signed [32:0] diff;
      diff = $signed({1'b0, meas}) - $signed({1'b0, expv});
      if (diff < 33'sd0) diff = -diff;
      return diff <= $signed({1'b0, TOL});
   endfunction

   always_comb begin
      state_d  = state_q;
      meas_d   = 1'b0;
      err_d    = 1'b0;
      complete = 1'b0;
      cap_hi   = 1'b0;
      clr_good = 1'b0;
`ifdef CLK_DIV_MON_STUCK_EN
      timeout  = 1'b0;
`endif
      good_ok  = in_tol(run_cnt, PERIOD_EXP) && in_tol(hi_tmp, HIGH_EXP);
      good_nx  = (good_cnt >= LOCK_CNT) ? LOCK_CNT : good_cnt + 8'd1;
      case (state_q)
         SEEK: if (rise) state_d = HIGH;
         HIGH: begin
            if (rise) begin
               err_d    = 1'b1;
               clr_good = 1'b1;
            end else if (fall) begin
               cap_hi  = 1'b1;
               state_d = LOW;
            end
`ifdef CLK_DIV_MON_STUCK_EN
            else if (tmo_hit) begin
               timeout  = 1'b1;
               clr_good = 1'b1;
               state_d  = SEEK;
            end
`endif
         end
         LOW: begin
            if (rise) begin
               complete = 1'b1;
               meas_d   = 1'b1;
               err_d    = ~good_ok;
               clr_good = ~good_ok;
               state_d  = HIGH;
            end
`ifdef CLK_DIV_MON_STUCK_EN
            else if (tmo_hit) begin
               timeout  = 1'b1;
               clr_good = 1'b1;
               state_d  = SEEK;
            end
`endif
         end
         default: state_d = SEEK;
      endcase
      // disable overrides everything except edge ticks and the held measurements
      if (!mon.en) begin
         state_d  = SEEK;
         meas_d   = 1'b0;
         err_d    = 1'b0;
         complete = 1'b0;
         cap_hi   = 1'b0;
         clr_good = 1'b1;
`ifdef CLK_DIV_MON_STUCK_EN
         timeout  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge phase_rst) begin
      if (phase_rst) begin
         state_q        <= SEEK;
         div_prev       <= 1'b1;
         run_cnt        <= 32'd0;
         hi_tmp         <= 32'd0;
         good_cnt       <= 8'd0;
         mon.rise_tick  <= 1'b0;
         mon.fall_tick  <= 1'b0;
         mon.high_len   <= 32'd0;
         mon.period_len <= 32'd0;
         mon.meas_valid <= 1'b0;
         mon.period_err <= 1'b0;
         mon.locked     <= 1'b0;
         mon.period_cnt <= 16'd0;
      end else begin
         state_q        <= state_d;
         div_prev       <= mon.div_in;
         mon.rise_tick  <= rise;
         mon.fall_tick  <= fall;
         mon.meas_valid <= meas_d;
         mon.period_err <= err_d;
         if (rise)
            run_cnt <= 32'd1;
         else if (run_cnt != 32'hFFFF_FFFF)
            run_cnt <= run_cnt + 32'd1;
         if (cap_hi) hi_tmp <= run_cnt;
         if (complete) begin
            mon.period_len <= run_cnt;
            mon.high_len   <= hi_tmp;
            mon.period_cnt <= mon.period_cnt + 16'd1;
         end
         if (clr_good) begin
            good_cnt   <= 8'd0;
            mon.locked <= 1'b0;
         end else if (complete) begin
            good_cnt   <= good_nx;
            mon.locked <= (good_nx == LOCK_CNT);
         end
      end
   end

`ifdef CLK_DIV_MON_STUCK_EN
   always_ff @(posedge clk or posedge phase_rst) begin
      if (phase_rst)
         mon.stuck <= 1'b0;
      else if (!mon.en || rise)
         mon.stuck <= 1'b0;
      else if (timeout)
         mon.stuck <= 1'b1;
   end
`else
   assign mon.stuck = 1'b0;
`endif

endmodule
